reg_trace_dump: RTL and testbench
=================================

Name: reg_trace_dump

Overview:
- Hardware debug and trace unit that sits between the processor and the regfile.
- During normal execution it logs every retired register write (cycle stamp, destination, value) into a small FIFO. The FIFO streams out over a valid/ready port.
- On request it halts the processor, drains the FIFO, then takes over regfile read port A. It walks registers 0..NUM_REGS-1 and streams each value out on the same port.
- This moves the simulation-only write-log and register-check flow into synthesizable hardware for on-board debug.

Parameters:
- FIFO_DEPTH, 8, number of write-trace entries buffered; power of two, at least 2.
- CYC_W, 16, width of the free-running cycle stamp.
- NUM_REGS, 32, number of registers scanned during a dump.

Ports:
- clock, in, 1, system clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-high; clears all state.
- ctrl_writeEnable, in, 1, regfile write enable from the processor.
- ctrl_writeReg, in, 5, regfile write address from the processor.
- data_writeReg, in, 32, regfile write data from the processor.
- cpu_readRegA, in, 5, processor's read-port-A address.
- ctrl_readRegA, out, 5, read-port-A address driven to the regfile.
- data_readRegA, in, 32, regfile read-port-A data (combinational read).
- dump_start, in, 1, single-cycle request to begin a register dump.
- halt, out, 1, stall request to the processor.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, consumer accepts the beat.
- out_kind, out, 1, 0 = write-trace entry, 1 = register-dump entry.
- out_reg, out, 5, register index of the beat.
- out_cycle, out, CYC_W, cycle stamp of the beat (0 for dump beats).
- out_data, out, 32, register value of the beat.
- overflow, out, 1, sticky flag: a trace entry was dropped.
- dump_done, out, 1, dump complete.

Behaviour:
- Reset values:
  - state = RUN; FIFO empty; cycle counter = 0; scan index = 0.
  - halt = 0, out_valid = 0, out_kind = 0, out_reg = 0, out_cycle = 0, out_data = 0, overflow = 0, dump_done = 0.
  - Reset asserted mid-dump returns every output to these values on the next edge, and pass-through of read port A resumes.
- Cycle counter:
  - Reads 0 in the first cycle after reset deasserts, then increments by 1 per clock and wraps modulo 2^CYC_W.
  - Frozen while halt = 1.
- ctrl_readRegA:
  - Combinational mux: equals cpu_readRegA in RUN and DRAIN.
  - Equals the scan index in SCAN_RD, SCAN_OUT and DONE.
- Trace capture (RUN and DRAIN only):
  - Push when ctrl_writeEnable = 1 and ctrl_writeReg != 0.
  - Pushed entry = {current cycle, ctrl_writeReg, data_writeReg}.
  - Writes to r0 are never logged.
- FIFO:
  - Head is registered; out_valid = not empty; no same-cycle bypass. A push into an empty FIFO appears on the output at the next edge.
  - Pop when out_valid and out_ready.
  - Push while full with no pop: entry dropped, overflow set; overflow stays set until reset.
  - Push and pop in the same cycle while full: both take effect, no overflow.
  - Output order = write order.
- State machine:
  - RUN:
    - halt = 0; trace beats stream.
    - dump_start = 1 goes to DRAIN; halt reads 1 from the next cycle on.
  - DRAIN:
    - halt = 1; trace beats continue.
    - Writes still in the processor pipeline are still logged.
    - Moves to SCAN_RD on the first cycle the FIFO is empty and no push occurs.
  - SCAN_RD:
    - Drives ctrl_readRegA = index and registers data_readRegA into the output register.
    - Next state SCAN_OUT.
  - SCAN_OUT:
    - out_valid = 1, out_kind = 1, out_reg = index, out_cycle = 0.
    - Output is held stable until out_ready.
    - On handshake: if index = NUM_REGS-1, go to DONE; otherwise index+1 and go to SCAN_RD.
  - DONE:
    - halt = 1, dump_done = 1, out_valid = 0.
    - Stays in DONE until reset.
- dump_start is ignored in every state except RUN.
- Output beats are never duplicated or skipped, regardless of the out_ready pattern.
- Dump latency: at least 2 cycles per register. With out_ready held at 1, a full dump takes 2*NUM_REGS cycles after DRAIN exits.

Test Plan:
1. Reset, out_ready = 1; write rd = 5, data = 42 in cycle 3 → next cycle out_valid = 1, kind = 0, reg = 5, data = 42, cycle = 3; out_valid = 0 afterwards.
2. Write rd = 0, data = 99 → no beat, FIFO stays empty. Writes to r7 and then r9 in consecutive cycles → two beats in order with consecutive cycle stamps.
3. out_ready = 0; 10 writes to r1..r10 (data = 100+i) with FIFO_DEPTH = 8 → overflow = 1. Release out_ready → exactly r1..r8 streamed in order, overflow stays 1.
4. FIFO full and out_ready = 1; one write to r11 in the same cycle → no overflow, count stays 8, r11 appears last.
5. Regfile preloaded with r_i = 3*i; 3 trace entries pending; pulse dump_start with out_ready toggling 1,0,1,0 → halt = 1 next cycle; 3 trace beats drain first; then 32 kind = 1 beats with reg 0..31 and data 0..93, with no gaps or duplicates; ctrl_readRegA = index during the scan; dump_done = 1 after the reg 31 handshake; a later dump_start is ignored.
6. Assert reset while scanning index 10 → all outputs return to reset values on the next edge; ctrl_readRegA follows cpu_readRegA again; the cycle counter restarts at 0.

Source files
------------

// File: rtl/reg_trace_dump.sv
// rtl/reg_trace_dump.sv - register write trace FIFO with halt-and-dump register scan
module reg_trace_dump #(
  parameter int FIFO_DEPTH = 8,
  parameter int CYC_W      = 16,
  parameter int NUM_REGS   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_writeEnable,
  input  logic [4:0]       ctrl_writeReg,
  input  logic [31:0]      data_writeReg,
  input  logic [4:0]       cpu_readRegA,
  output logic [4:0]       ctrl_readRegA,
  input  logic [31:0]      data_readRegA,
  input  logic             dump_start,
  output logic             halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_kind,
  output logic [4:0]       out_reg,
  output logic [CYC_W-1:0] out_cycle,
  output logic [31:0]      out_data,
  output logic             overflow,
  output logic             dump_done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = CYC_W + 37;
  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {RUN, DRAIN, SCAN_RD, SCAN_OUT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q;
  logic [4:0]        idx_q, idx_d;
  logic [31:0]       dump_q;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [PW:0]       cnt_q;
  logic              ovf_q;

  logic              trace_mode, fifo_empty, fifo_full, push, pop, do_push;
  logic [EW-1:0]     head;

  assign trace_mode = (state_q == RUN) || (state_q == DRAIN);
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign push       = trace_mode && ctrl_writeEnable && (ctrl_writeReg != 5'd0);
  assign pop        = trace_mode && !fifo_empty && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push    = push && (!fifo_full || pop);
  assign head       = mem_q[rd_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RUN:      if (dump_start) state_d = DRAIN;
      DRAIN:    if (fifo_empty && !push) state_d = SCAN_RD;
      SCAN_RD:  state_d = SCAN_OUT;
      SCAN_OUT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = SCAN_RD;
          end
        end
      end
      DONE:     state_d = DONE;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_kind  = 1'b0;
    out_reg   = 5'd0;
    out_cycle = '0;
    out_data  = 32'd0;
    if (trace_mode && !fifo_empty) begin
      out_valid = 1'b1;
      out_reg   = head[36:32];
      out_cycle = head[EW-1:37];
      out_data  = head[31:0];
    end else if (state_q == SCAN_OUT) begin
      out_valid = 1'b1;
      out_kind  = 1'b1;
      out_reg   = idx_q;
      out_data  = dump_q;
    end
    halt          = (state_q != RUN);
    dump_done     = (state_q == DONE);
    ctrl_readRegA = trace_mode ? cpu_readRegA : idx_q;
    overflow      = ovf_q;
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= {cyc_q, ctrl_writeReg, data_writeReg};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cyc_q   <= '0;
      idx_q   <= 5'd0;
      dump_q  <= 32'd0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (!halt) cyc_q <= cyc_q + CYC_W'(1);
      if (state_q == SCAN_RD) dump_q <= data_readRegA;
      if (do_push) wr_q <= wr_q + PW'(1);
      if (pop) rd_q <= rd_q + PW'(1);
      if (do_push && !pop) cnt_q <= cnt_q + (PW+1)'(1);
      else if (!do_push && pop) cnt_q <= cnt_q - (PW+1)'(1);
      if (push && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_trace_dump.sv
// tb/tb_reg_trace_dump.sv - scoreboard bench for reg_trace_dump
module tb_reg_trace_dump;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_writeEnable = 1'b0;
  logic [4:0]  ctrl_writeReg = 5'd0;
  logic [31:0] data_writeReg = 32'd0;
  logic [4:0]  cpu_readRegA = 5'd13;
  logic [4:0]  ctrl_readRegA;
  logic [31:0] data_readRegA;
  logic        dump_start = 1'b0;
  logic        halt;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_kind;
  logic [4:0]  out_reg;
  logic [15:0] out_cycle;
  logic [31:0] out_data;
  logic        overflow;
  logic        dump_done;

  int checks = 0;
  int failures = 0;
  int tcyc = 0;
  logic [53:0] exp_q[$];

  reg_trace_dump dut (
    .clock(clock), .reset(reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .cpu_readRegA(cpu_readRegA),
    .ctrl_readRegA(ctrl_readRegA), .data_readRegA(data_readRegA),
    .dump_start(dump_start), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_reg(out_reg), .out_cycle(out_cycle), .out_data(out_data),
    .overflow(overflow), .dump_done(dump_done)
  );

  // Regfile preloaded with r_i = 3*i.
  assign data_readRegA = 32'(ctrl_readRegA) * 32'd3;

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat act=%0h exp=none",
                 {out_kind, out_reg, out_cycle, out_data});
      end else begin
        chk("beat", 64'({out_kind, out_reg, out_cycle, out_data}), 64'(exp_q.pop_front()));
      end
      if (out_kind) chk("scan_addr", 64'(ctrl_readRegA), 64'(out_reg));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    tcyc++;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d, input bit log_it);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = r;
    data_writeReg    = d;
    if (log_it) exp_q.push_back({1'b0, r, 16'(tcyc), d});
    step();
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, 64'({halt, out_valid, out_kind, out_reg, out_cycle, out_data, overflow, dump_done}), 64'd0);
    chk({name, "_rda"}, 64'(ctrl_readRegA), 64'(cpu_readRegA));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    chk_reset_outs("reset_outs");
    reset = 1'b0;
    tcyc  = 0;
  endtask

  initial begin
    bit found;
    // 1: first logged write in cycle 3
    do_reset();
    repeat (3) step();
    wr(5'd5, 32'd42, 1'b1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    step();
    chk("t1_drained", 64'(out_valid), 64'd0);

    // 2: r0 writes are not logged; back-to-back writes keep order
    wr(5'd0, 32'd99, 1'b0);
    chk("t2_r0_empty", 64'(out_valid), 64'd0);
    wr(5'd7, 32'd77, 1'b1);
    wr(5'd9, 32'd99, 1'b1);
    repeat (4) step();
    chk("t2_drained", 64'(out_valid), 64'd0);

    // 3: overflow with consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) wr(5'(i), 32'(100 + i), i <= 8);
    chk("t3_overflow", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    repeat (12) step();
    chk("t3_overflow_sticky", 64'(overflow), 64'd1);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // 4: push and pop together while full
    out_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) wr(5'(i), 32'(200 + i), 1'b1);
    out_ready = 1'b1;
    wr(5'd11, 32'd311, 1'b1);
    repeat (12) step();
    chk("t4_no_overflow", 64'(overflow), 64'd0);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // 5: drain then full dump under a toggling consumer
    out_ready = 1'b0;
    wr(5'd20, 32'h20, 1'b1);
    wr(5'd21, 32'h21, 1'b1);
    wr(5'd22, 32'h22, 1'b1);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    chk("t5_halt", 64'(halt), 64'd1);
    // In-flight write during DRAIN carries the frozen stamp.
    wr(5'd23, 32'h123, 1'b1);
    for (int i = 0; i < 32; i++) exp_q.push_back({1'b1, 5'(i), 16'd0, 32'(3 * i)});
    for (int n = 0; n < 400 && !dump_done; n++) begin
      out_ready = !out_ready;
      step();
    end
    chk("t5_done", 64'(dump_done), 64'd1);
    chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t5_idle_outs", 64'({halt, out_valid}), 64'b10);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    step();
    chk("t5_start_ignored", 64'({dump_done, halt, out_valid}), 64'b110);

    // 6: reset in the middle of a scan
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b1, 5'(i), 16'd0, 32'(3 * i)});
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (out_valid && out_kind && out_reg == 5'd10) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("t6_reached_idx10", 64'(found), 64'd1);
    reset = 1'b1;
    step();
    chk_reset_outs("t6_reset_outs");
    cpu_readRegA = 5'd17;
    #1;
    chk("t6_rda_passthru", 64'(ctrl_readRegA), 64'd17);
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    reset = 1'b0;
    tcyc  = 0;
    wr(5'd3, 32'h33, 1'b1);
    repeat (3) step();
    chk("t6_cycle_restart", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
